// File: rtl/acc_tilt_filter_pkg.sv
// rtl/acc_tilt_filter_pkg.sv - shared state encoding, tilt bit indices and hysteresis helper
package acc_filt_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    AX_X    = 3'd2,
    AX_Y    = 3'd3,
    AX_Z    = 3'd4,
    UPDATE  = 3'd5
  } filt_state_t;

  localparam int RIGHT = 0;
  localparam int LEFT  = 1;
  localparam int DOWN  = 2;
  localparam int UP    = 3;

  // Returns {neg, pos} direction bits; values between the thresholds keep the current bit.
  function automatic logic [1:0] tilt_pair(input logic signed [DATA_W-1:0] v,
                                           input logic [1:0] cur,
                                           input int on_th,
                                           input int off_th);
    logic [1:0] nxt;
    nxt = cur;
    if (v > on_th) nxt[0] = 1'b1;
    else if (v < off_th) nxt[0] = 1'b0;
    if (v < -on_th) nxt[1] = 1'b1;
    else if (v > -off_th) nxt[1] = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/acc_tilt_filter_if.sv
// rtl/acc_tilt_filter_if.sv - filtered-output bundle between the filter and its consumers
interface acc_filt_if;
  import acc_filt_pkg::*;

  logic signed [DATA_W-1:0] x_filt;
  logic signed [DATA_W-1:0] y_filt;
  logic signed [DATA_W-1:0] z_filt;
  logic                     filt_valid;
  logic [3:0]               tilt_dir;
  logic [2:0]               filt_state;

  modport master (output x_filt, y_filt, z_filt, filt_valid, tilt_dir, filt_state);
  modport slave  (input  x_filt, y_filt, z_filt, filt_valid, tilt_dir, filt_state);
endinterface

// File: rtl/acc_tilt_filter_axis_avg.sv
// rtl/acc_tilt_filter_axis_avg.sv - per-axis history ring and running sum
module acc_axis_avg
  import acc_filt_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                            clk_50,
  input  logic                            reset,
  input  logic                            en,
  input  logic [AVG_LOG2-1:0]             wptr,
  input  logic signed [DATA_W-1:0]        din,
  output logic signed [DATA_W+AVG_LOG2-1:0] sum
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic signed [DATA_W-1:0] hist [DEPTH];
  logic signed [SUM_W-1:0]  din_ext;
  logic signed [SUM_W-1:0]  old_ext;

  assign din_ext = din;
  assign old_ext = hist[wptr];

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (en) begin
      sum        <= sum - old_ext + din_ext;
      hist[wptr] <= din;
    end
  end

endmodule

// File: rtl/acc_tilt_filter.sv
// rtl/acc_tilt_filter.sv - sample-rate tick, per-axis moving average and hysteretic tilt code
module acc_tilt_filter
  import acc_filt_pkg::*;
#(
  parameter int SAMPLE_DIV = 500000,
  parameter int AVG_LOG2   = 3,
  parameter int TILT_ON    = 200,
  parameter int TILT_OFF   = 120
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_acc_reg,
  input  logic signed [DATA_W-1:0] y_acc_reg,
  input  logic signed [DATA_W-1:0] z_acc_reg,
  output logic signed [DATA_W-1:0] x_filt,
  output logic signed [DATA_W-1:0] y_filt,
  output logic signed [DATA_W-1:0] z_filt,
  output logic                     filt_valid,
  output logic [3:0]               tilt_dir,
  output logic [2:0]               filt_state
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int SUM_W = DATA_W + AVG_LOG2;

  filt_state_t state_q, state_d;
  logic [CNT_W-1:0]         cnt;
  logic                     tick;
  logic [AVG_LOG2-1:0]      wptr;
  logic signed [DATA_W-1:0] snap_x, snap_y, snap_z;
  logic signed [SUM_W-1:0]  sum_x, sum_y, sum_z;
  logic signed [DATA_W-1:0] nx, ny, nz;
  logic [1:0]               pair_x, pair_y;
  logic [3:0]               tilt_d;

  assign tick       = (cnt == CNT_W'(SAMPLE_DIV - 1));
  assign filt_state = state_q;

  // Arithmetic shift right then truncate is just the upper DATA_W bits of the sum.
  assign nx = sum_x[SUM_W-1:AVG_LOG2];
  assign ny = sum_y[SUM_W-1:AVG_LOG2];
  assign nz = sum_z[SUM_W-1:AVG_LOG2];

  assign pair_x = tilt_pair(nx, {tilt_dir[LEFT], tilt_dir[RIGHT]}, TILT_ON, TILT_OFF);
  assign pair_y = tilt_pair(ny, {tilt_dir[DOWN], tilt_dir[UP]},    TILT_ON, TILT_OFF);

  always_comb begin
    tilt_d        = '0;
    tilt_d[RIGHT] = pair_x[0];
    tilt_d[LEFT]  = pair_x[1];
    tilt_d[UP]    = pair_y[0];
    tilt_d[DOWN]  = pair_y[1];
  end

  always_ff @(posedge clk_50) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = CAPTURE;
      CAPTURE: state_d = AX_X;
      AX_X:    state_d = AX_Y;
      AX_Y:    state_d = AX_Z;
      AX_Z:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      cnt        <= '0;
      wptr       <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_z     <= '0;
      x_filt     <= '0;
      y_filt     <= '0;
      z_filt     <= '0;
      tilt_dir   <= '0;
      filt_valid <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      filt_valid <= (state_q == UPDATE);
      if (state_q == CAPTURE) begin
        snap_x <= x_acc_reg;
        snap_y <= y_acc_reg;
        snap_z <= z_acc_reg;
      end
      if (state_q == UPDATE) begin
        x_filt   <= nx;
        y_filt   <= ny;
        z_filt   <= nz;
        tilt_dir <= tilt_d;
        wptr     <= wptr + 1'b1;
      end
    end
  end

  acc_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
    .clk_50(clk_50), .reset(reset), .en(state_q == AX_X), .wptr(wptr), .din(snap_x), .sum(sum_x)
  );
  acc_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
    .clk_50(clk_50), .reset(reset), .en(state_q == AX_Y), .wptr(wptr), .din(snap_y), .sum(sum_y)
  );
  acc_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_z (
    .clk_50(clk_50), .reset(reset), .en(state_q == AX_Z), .wptr(wptr), .din(snap_z), .sum(sum_z)
  );

endmodule
